// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed, byte-lane-aware load/store unit between EXMA and MAWB.
// Accepts byte/half/word(/dword) accesses through a req/ready handshake and returns
// sign- or zero-extended load data RD_LAT cycles after each accept. It flags misaligned
// and out-of-range accesses, and after reset it can clear the array with a sweep.
// Ports:
//   clkIn, resetIn (async, active low)
//   ReqIn/WriteIn/SizeIn/SignedIn/AddrIn/DataIn : request from EXMA
//   ReadyOut : a request can be accepted this cycle
//   ValidOut/DataOut/FaultOut : response pulse to MAWB
//   BusyOut  : clear sweep in progress
module data_mem_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic              ReqIn,
  input  logic              WriteIn,
  input  logic [1:0]        SizeIn,
  input  logic              SignedIn,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ReadyOut,
  output logic              ValidOut,
  output logic [DATA_W-1:0] DataOut,
  output logic              FaultOut,
  output logic              BusyOut
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(NB);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned MEM_BYTES = DEPTH * NB;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               ready, busy, clr_we;
  logic               acc;

  logic [2:0]         off;
  logic [IDX_W-1:0]   idx;
  logic               range_err, align_err, fault;
  int unsigned        off_u, nbytes, width;
  logic [NB-1:0]      be;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  wr_data;
  logic [NB-1:0]      wr_be;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  rd_word, shifted, ext, resp_data;
  logic               sbit;

  logic [RD_LAT-1:0]             vld_q, vld_d, flt_q, flt_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_q, dat_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      if (CLEAR_ON_RESET != 0) state_q <= ST_CLEAR;
      else                     state_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

  // Outputs must read 0 the moment reset is asserted, independent of the clock.
  assign ReadyOut = ready & resetIn;
  assign BusyOut  = busy & resetIn;
  assign acc      = ReqIn & ReadyOut;

  // ---------------- Address decode and fault detection ----------------
  always_comb begin
    off = '0;
    off[OFF_W-1:0] = AddrIn[OFF_W-1:0];
    idx       = AddrIn[OFF_W +: IDX_W];
    range_err = ({1'b0, AddrIn} >= MEM_LIMIT);
    case (SizeIn)
      2'd1:    align_err = off[0];
      2'd2:    align_err = (off[1:0] != 2'b00);
      2'd3:    align_err = (DATA_W == 32) || (off != 3'b000);
      default: align_err = 1'b0;
    endcase
    fault  = range_err | align_err;
    off_u  = 32'(off);
    nbytes = 32'd1 << SizeIn;
    width  = 32'd8 << SizeIn;
    for (int unsigned b = 0; b < NB; b++) begin
      be[b] = (b >= off_u) && (b < off_u + nbytes);
    end
  end

  // ---------------- Array write port (clear sweep or store) ----------------
  always_comb begin
    wr_en   = (clr_we & resetIn) | (acc & WriteIn & ~fault);
    wr_idx  = idx;
    wr_data = DataIn << (8 * off_u);
    wr_be   = be;
    if (clr_we) begin
      wr_idx  = cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- Load extraction and extension ----------------
  always_comb begin
    rd_word = mem_q[idx];
    shifted = rd_word >> (8 * off_u);
    case (SizeIn)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[DATA_W-1];
    endcase
    ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ext[i] = (i < width) ? shifted[i] : (SignedIn & sbit);
    end
    resp_data = (fault | WriteIn) ? '0 : ext;
  end

  // ---------------- Response pipeline (RD_LAT stages) ----------------
  always_comb begin
    vld_d    = '0;
    flt_d    = '0;
    dat_d    = '0;
    vld_d[0] = acc;
    flt_d[0] = acc & fault;
    dat_d[0] = acc ? resp_data : '0;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      flt_d[i] = flt_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      vld_q <= '0;
      flt_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      flt_q <= flt_d;
      dat_q <= dat_d;
    end
  end

  assign ValidOut = vld_q[RD_LAT-1];
  assign FaultOut = flt_q[RD_LAT-1];
  assign DataOut  = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with defaults (RD_LAT=1) and a
// second with RD_LAT=2, both driven by the same request stream.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ReqIn, WriteIn, SignedIn;
  logic [1:0]  SizeIn;
  logic [31:0] AddrIn, DataIn;

  logic        ReadyOut, ValidOut, FaultOut, BusyOut;
  logic [31:0] DataOut;
  logic        ready2, valid2, fault2, busy2;
  logic [31:0] data2;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;
  int vld_seen;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_dut (
    .clkIn(clk), .resetIn(rst_n), .ReqIn(ReqIn), .WriteIn(WriteIn), .SizeIn(SizeIn),
    .SignedIn(SignedIn), .AddrIn(AddrIn), .DataIn(DataIn), .ReadyOut(ReadyOut),
    .ValidOut(ValidOut), .DataOut(DataOut), .FaultOut(FaultOut), .BusyOut(BusyOut));

  data_mem_ctrl #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clkIn(clk), .resetIn(rst_n), .ReqIn(ReqIn), .WriteIn(WriteIn), .SizeIn(SizeIn),
    .SignedIn(SignedIn), .AddrIn(AddrIn), .DataIn(DataIn), .ReadyOut(ready2),
    .ValidOut(valid2), .DataOut(data2), .FaultOut(fault2), .BusyOut(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resp1(input string tag, input logic v, input logic f, input logic [31:0] d);
    check(tag, 64'({ValidOut, FaultOut, DataOut}), 64'({v, f, d}));
  endtask

  task automatic resp2(input string tag, input logic v, input logic f, input logic [31:0] d);
    check(tag, 64'({valid2, fault2, data2}), 64'({v, f, d}));
  endtask

  task automatic drive(input logic req, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    ReqIn = req; WriteIn = wr; SizeIn = sz; SignedIn = sg; AddrIn = a; DataIn = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  // Counts BusyOut samples until ReadyOut rises; also records any ValidOut seen.
  task automatic count_sweep(output int nb, output int nv);
    nb = 0;
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ValidOut || valid2) nv++;
      if (ReadyOut) break;
      if (BusyOut) nb++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    // ---- 1: reset state and clear sweep ----
    check("rst_outs", 64'({ReadyOut, BusyOut, ValidOut, FaultOut, DataOut}), 64'h0);
    check("rst_outs2", 64'({ready2, busy2, valid2, fault2, data2}), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    count_sweep(busy_cnt, vld_seen);
    check("sweep_len", 64'(busy_cnt), 64'd32);
    check("ready_after", 64'({ReadyOut, BusyOut}), 64'b10);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    @(negedge clk); resp1("ld_0x00_clr", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);
    @(negedge clk); resp1("ld_0x7c_clr", 1'b1, 1'b0, 32'h0);
    idle();
    @(negedge clk); resp1("idle_quiet", 1'b0, 1'b0, 32'h0);

    // ---- 2: word store, signed byte / unsigned half loads ----
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h08, 32'h80FF7F01);
    @(negedge clk); resp1("st_w_08", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
    @(negedge clk); resp1("ldb_s_09", 1'b1, 1'b0, 32'h0000007F);
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h0B, 32'h0);
    @(negedge clk); resp1("ldb_s_0b", 1'b1, 1'b0, 32'hFFFFFF80);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
    @(negedge clk); resp1("ldh_u_0a", 1'b1, 1'b0, 32'h000080FF);
    idle();
    @(negedge clk); resp1("idle_quiet2", 1'b0, 1'b0, 32'h0);

    // ---- 3: byte store merged into word, back-to-back load ----
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344);
    @(negedge clk); resp1("st_w_0c", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h0D, 32'hFFFFFFAA);
    @(negedge clk); resp1("st_b_0d", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    @(negedge clk); resp1("ld_w_0c_merge", 1'b1, 1'b0, 32'h1122AA44);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    @(negedge clk); resp1("ld_w_08_keep", 1'b1, 1'b0, 32'h80FF7F01);
    drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
    @(negedge clk); resp1("ldh_s_0e", 1'b1, 1'b0, 32'h00001122);

    // ---- 4: faults ----
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    @(negedge clk); resp1("flt_ldh_03", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h06, 32'h12345678);
    @(negedge clk); resp1("flt_stw_06", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    @(negedge clk); resp1("flt_ldw_80", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
    @(negedge clk); resp1("flt_dword32", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF);
    @(negedge clk); resp1("flt_stw_80", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    @(negedge clk); resp1("ld_w_04_unchg", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    @(negedge clk); resp1("ld_w_00_unchg", 1'b1, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    @(negedge clk);
    resp2("lat2_drained", 1'b0, 1'b0, 32'h0);

    // ---- 5: RD_LAT=2 back-to-back loads ----
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    @(negedge clk); resp2("lat2_not_early", 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    @(negedge clk); resp2("lat2_r0", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    @(negedge clk); resp2("lat2_r1", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    @(negedge clk); resp2("lat2_r2", 1'b1, 1'b0, 32'h80FF7F01);
    resp1("lat1_r2", 1'b1, 1'b0, 32'h1122AA44);
    idle();
    @(negedge clk); resp2("lat2_r3", 1'b1, 1'b0, 32'h1122AA44);
    @(negedge clk); resp2("lat2_end", 1'b0, 1'b0, 32'h0);

    // ---- 6: reset mid-load and mid-sweep ----
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_midload", 64'({ReadyOut, BusyOut, ValidOut, FaultOut, DataOut}), 64'h0);
    check("rst_midload2", 64'({ready2, busy2, valid2, fault2, data2}), 64'h0);
    idle();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("mid_sweep_busy", 64'({ReadyOut, BusyOut}), 64'b01);
    #1 rst_n = 1'b0;
    #1;
    check("rst_midsweep", 64'({ReadyOut, BusyOut, ValidOut, FaultOut, DataOut}), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    count_sweep(busy_cnt, vld_seen);
    check("sweep_restart", 64'(busy_cnt), 64'd32);
    check("no_stale_valid", 64'(vld_seen), 64'd0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    @(negedge clk); resp1("ld_08_recleared", 1'b1, 1'b0, 32'h0);
    idle();
    @(negedge clk); resp1("final_quiet", 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
